// File: rtl/regfile_mp_if.sv
// Register file access bundle: read ports, write ports and scoreboard set.
// The master drives addresses/enables/data; the slave returns registered read data and busy bits.
interface regfile_mp_if #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2
);
   logic [NUM_RD-1:0]        rd_en;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic                     sb_set_en;
   logic [ADDR_W-1:0]        sb_set_addr;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
      input  rd_data, rd_busy
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
      output rd_data, rd_busy
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard; optional REGFILE_BYPASS_EN forwards same-cycle writes to reads.
// Latency: 1 cycle address-to-data; read ports hold while rd_en is low.
// Backpressure: none, every enabled access completes in the cycle it is presented.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic         clk,
   input  logic         rst,
   regfile_mp_if.slave  bus
);

   logic [DATA_W-1:0]              regs [NUM_REGS];
   logic [NUM_REGS-1:0]            busy;
   logic [NUM_REGS-1:0]            busy_nxt;
   logic [NUM_RD-1:0][DATA_W-1:0]  rd_val;
   logic [NUM_RD-1:0]              rd_bsy;
   logic [NUM_RD*DATA_W-1:0]       rd_data_q;
   logic [NUM_RD-1:0]              rd_busy_q;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Writes retire (clear) before the issue-side set so a new producer wins.
   always_comb begin
      busy_nxt = busy;
      for (int w = 0; w < NUM_WR; w++) begin
         if (bus.wr_en[w]) begin
            busy_nxt[bus.wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
         end
      end
      if (bus.sb_set_en && !is_zero(bus.sb_set_addr)) begin
         busy_nxt[bus.sb_set_addr] = 1'b1;
      end
   end

   always_comb begin
      rd_val = '0;
      rd_bsy = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         rd_val[p] = regs[bus.rd_addr[p*ADDR_W +: ADDR_W]];
         rd_bsy[p] = busy[bus.rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
         for (int w = 0; w < NUM_WR; w++) begin
            if (bus.wr_en[w] &&
                bus.wr_addr[w*ADDR_W +: ADDR_W] == bus.rd_addr[p*ADDR_W +: ADDR_W]) begin
               rd_val[p] = bus.wr_data[w*DATA_W +: DATA_W];
            end
         end
`endif
         if (is_zero(bus.rd_addr[p*ADDR_W +: ADDR_W])) begin
            rd_val[p] = '0;
            rd_bsy[p] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= DATA_W'(i);
         end
         busy      <= '0;
         rd_data_q <= '0;
         rd_busy_q <= '0;
      end else begin
         // Later iterations override earlier ones, so the higher write port wins.
         for (int w = 0; w < NUM_WR; w++) begin
            if (bus.wr_en[w] && !is_zero(bus.wr_addr[w*ADDR_W +: ADDR_W])) begin
               regs[bus.wr_addr[w*ADDR_W +: ADDR_W]] <= bus.wr_data[w*DATA_W +: DATA_W];
            end
         end
         busy <= busy_nxt;
         for (int p = 0; p < NUM_RD; p++) begin
            if (bus.rd_en[p]) begin
               rd_data_q[p*DATA_W +: DATA_W] <= rd_val[p];
               rd_busy_q[p]                  <= rd_bsy[p];
            end
         end
      end
   end

   assign bus.rd_data = rd_data_q;
   assign bus.rd_busy = rd_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench for regfile_mp with default parameters (32x32, 2 read, 2 write, zero reg).
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic        rst;
      logic [1:0]  re;
      logic [4:0]  ra0, ra1;
      logic [1:0]  we;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic        se;
      logic [4:0]  sa;
      logic [31:0] e0, e1;
      logic [1:0]  eb;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) bus ();

   regfile_mp #(
      .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic vec_t mk(
      input logic r, input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
      input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
      input logic [31:0] wd0, input logic [31:0] wd1, input logic se, input logic [4:0] sa,
      input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
      vec_t v;
      v.rst = r;  v.re = re;  v.ra0 = ra0; v.ra1 = ra1;
      v.we = we;  v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
      v.se = se;  v.sa = sa;  v.e0 = e0;  v.e1 = e1;  v.eb = eb;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic drive(input vec_t v);
      rst             = v.rst;
      bus.rd_en       = v.re;
      bus.rd_addr     = {v.ra1, v.ra0};
      bus.wr_en       = v.we;
      bus.wr_addr     = {v.wa1, v.wa0};
      bus.wr_data     = {v.wd1, v.wd0};
      bus.sb_set_en   = v.se;
      bus.sb_set_addr = v.sa;
   endtask

   task automatic apply_check(input vec_t v, input string tag);
      drive(v);
      @(posedge clk);
      #1;
      check({tag, " rd_data0"}, bus.rd_data[31:0],  v.e0);
      check({tag, " rd_data1"}, bus.rd_data[63:32], v.e1);
      check({tag, " rd_busy"},  {30'd0, bus.rd_busy}, {30'd0, v.eb});
   endtask

   initial begin
      vec_t v;
      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      //          rst re  ra0 ra1 we  wa0 wa1 wd0            wd1        se sa  e0                      e1                      eb
      vecs.push_back(mk(1, 2'b00, 0, 0,  2'b00, 0, 0, 0,             0,         0, 0,  0,                      0,                      2'b00));
      vecs.push_back(mk(0, 2'b11, 5, 31, 2'b00, 0, 0, 0,             0,         0, 0,  5,                      31,                     2'b00));
      vecs.push_back(mk(0, 2'b00, 5, 31, 2'b11, 7, 0, 32'hDEADBEEF,  32'h1234,  0, 0,  5,                      31,                     2'b00));
      vecs.push_back(mk(0, 2'b11, 7, 0,  2'b00, 0, 0, 0,             0,         0, 0,  32'hDEADBEEF,           0,                      2'b00));
      vecs.push_back(mk(0, 2'b00, 7, 0,  2'b11, 3, 3, 32'hAAAA,      32'hBBBB,  0, 0,  32'hDEADBEEF,           0,                      2'b00));
      vecs.push_back(mk(0, 2'b11, 3, 3,  2'b00, 0, 0, 0,             0,         0, 0,  32'hBBBB,               32'hBBBB,               2'b00));
      vecs.push_back(mk(0, 2'b11, 9, 8,  2'b01, 9, 0, 32'h55,        0,         0, 0,  BYP ? 32'h55 : 32'd9,   8,                      2'b00));
      vecs.push_back(mk(0, 2'b11, 9, 3,  2'b00, 0, 0, 0,             0,         0, 0,  32'h55,                 32'hBBBB,               2'b00));
      vecs.push_back(mk(0, 2'b11, 4, 4,  2'b00, 0, 0, 0,             0,         1, 4,  4,                      4,                      2'b00));
      vecs.push_back(mk(0, 2'b11, 4, 5,  2'b00, 0, 0, 0,             0,         0, 0,  4,                      5,                      2'b01));
      vecs.push_back(mk(0, 2'b11, 4, 4,  2'b01, 4, 0, 32'h44,        0,         1, 4,  BYP ? 32'h44 : 32'd4,   BYP ? 32'h44 : 32'd4,   2'b11));
      vecs.push_back(mk(0, 2'b11, 4, 4,  2'b00, 0, 0, 0,             0,         0, 0,  32'h44,                 32'h44,                 2'b11));
      vecs.push_back(mk(0, 2'b10, 4, 6,  2'b10, 0, 4, 0,             32'h45,    0, 0,  32'h44,                 6,                      2'b01));
      vecs.push_back(mk(0, 2'b11, 4, 4,  2'b00, 0, 0, 0,             0,         0, 0,  32'h45,                 32'h45,                 2'b00));
      vecs.push_back(mk(0, 2'b00, 4, 4,  2'b00, 0, 0, 0,             0,         1, 0,  32'h45,                 32'h45,                 2'b00));
      vecs.push_back(mk(0, 2'b11, 0, 4,  2'b00, 0, 0, 0,             0,         0, 0,  0,                      32'h45,                 2'b00));
      vecs.push_back(mk(0, 2'b11, 2, 1,  2'b00, 0, 0, 0,             0,         1, 10, 2,                      1,                      2'b00));
      vecs.push_back(mk(0, 2'b00, 10, 10, 2'b00, 0, 0, 0,            0,         0, 0,  2,                      1,                      2'b00));
      vecs.push_back(mk(0, 2'b00, 10, 10, 2'b00, 0, 0, 0,            0,         0, 0,  2,                      1,                      2'b00));
      vecs.push_back(mk(0, 2'b00, 10, 10, 2'b00, 0, 0, 0,            0,         0, 0,  2,                      1,                      2'b00));
      vecs.push_back(mk(0, 2'b11, 10, 2, 2'b00, 0, 0, 0,             0,         0, 0,  10,                     2,                      2'b01));
      vecs.push_back(mk(1, 2'b11, 10, 2, 2'b01, 2, 0, 32'hFF,        0,         1, 2,  0,                      0,                      2'b00));
      vecs.push_back(mk(0, 2'b11, 2, 10, 2'b00, 0, 0, 0,             0,         0, 0,  2,                      10,                     2'b00));
      vecs.push_back(mk(0, 2'b11, 11, 11, 2'b11, 11, 11, 32'h111,    32'h222,   0, 0,  BYP ? 32'h222 : 32'd11, BYP ? 32'h222 : 32'd11, 2'b00));
      vecs.push_back(mk(0, 2'b11, 11, 0, 2'b00, 0, 0, 0,             0,         0, 0,  32'h222,                0,                      2'b00));

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         apply_check(vecs[i], $sformatf("vec%0d", i));
      end

      // Fresh reset, then sweep every register on both ports to confirm the reset image.
      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      for (int i = 0; i < 32; i++) begin
         v = mk(0, 2'b11, 5'(i), 5'(31 - i), 2'b00, 0, 0, 0, 0, 0, 0,
                32'(i), 32'(31 - i), 2'b00);
         apply_check(v, $sformatf("sweep%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
